pid_sequencer: RTL and testbench

- Time-multiplexes one shared shift-add PID datapath across 2^aw control channels.
- Generates the slot timing: prescaler, channel address, 8-step arithmetic step index, the calc strobe and the readout ce strobe.
- Owns the per-channel coefficient register file (staging/active double buffer), channel enable mask and accumulator-clear requests, so the datapath holds only arithmetic state.
- Sits between the CPU I/O register block and the PID arithmetic unit.

---
 rtl/pid_seq_pkg.sv | 25 ++
 rtl/pid_coef_bank.sv | 65 ++++++
 rtl/pid_sequencer.sv | 105 ++++++++++
 tb/tb_pid_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pid_seq_pkg.sv
// Shared encodings for the PID slot sequencer: arithmetic step indices,
// coefficient select codes and the default coefficient width.
package pid_seq_pkg;

    localparam int CW_DEF = 6;

    typedef enum logic [2:0] {
        STEP_LATCH = 3'd0,
        STEP_ERR   = 3'd1,
        STEP_P     = 3'd2,
        STEP_I     = 3'd3,
        STEP_D     = 3'd4,
        STEP_SUM   = 3'd5,
        STEP_SAT   = 3'd6,
        STEP_OUT   = 3'd7
    } step_e;

    typedef enum logic [1:0] {
        SEL_KP  = 2'd0,
        SEL_KI  = 2'd1,
        SEL_KD  = 2'd2,
        SEL_RSV = 2'd3
    } coef_sel_e;

endpackage

// File: rtl/pid_coef_bank.sv
// Per-channel coefficient file: staging written by the CPU, active copied on commit.
// Latency: write/commit take effect on the next cycle; read mux is combinational; no backpressure.
// Flow control: none, every write is accepted in the cycle it is presented.
module pid_coef_bank
    import pid_seq_pkg::*;
#(
    parameter int aw = 1,
    parameter int cw = CW_DEF
) (
    input  logic                 clk_pid,
    input  logic                 reset,
    input  logic                 i_wr,
    input  logic [aw-1:0]        i_wr_ch,
    input  logic [1:0]           i_wr_sel,
    input  logic signed [cw-1:0] i_wr_data,
    input  logic                 i_commit,
    input  logic [aw-1:0]        i_a,
    output logic signed [cw-1:0] o_kp,
    output logic signed [cw-1:0] o_ki,
    output logic signed [cw-1:0] o_kd
);

    localparam int AN = 1 << aw;

    logic signed [cw-1:0] r_stg_kp [AN];
    logic signed [cw-1:0] r_stg_ki [AN];
    logic signed [cw-1:0] r_stg_kd [AN];
    logic signed [cw-1:0] r_act_kp [AN];
    logic signed [cw-1:0] r_act_ki [AN];
    logic signed [cw-1:0] r_act_kd [AN];

    // Commit reads staging before this edge's write lands, so a same-edge
    // write is deferred to the following frame.
    always_ff @(posedge clk_pid) begin
        if (!reset) begin
            for (int i = 0; i < AN; i++) begin
                r_stg_kp[i] <= '0;
                r_stg_ki[i] <= '0;
                r_stg_kd[i] <= '0;
                r_act_kp[i] <= '0;
                r_act_ki[i] <= '0;
                r_act_kd[i] <= '0;
            end
        end else begin
            if (i_commit) begin
                r_act_kp[i_a] <= r_stg_kp[i_a];
                r_act_ki[i_a] <= r_stg_ki[i_a];
                r_act_kd[i_a] <= r_stg_kd[i_a];
            end
            if (i_wr) begin
                case (coef_sel_e'(i_wr_sel))
                    SEL_KP:  r_stg_kp[i_wr_ch] <= i_wr_data;
                    SEL_KI:  r_stg_ki[i_wr_ch] <= i_wr_data;
                    SEL_KD:  r_stg_kd[i_wr_ch] <= i_wr_data;
                    default: ;
                endcase
            end
        end
    end

    assign o_kp = r_act_kp[i_a];
    assign o_ki = r_act_ki[i_a];
    assign o_kd = r_act_kd[i_a];

endmodule

// File: rtl/pid_sequencer.sv
// Slot timing, coefficient ownership and clear requests for a time-multiplexed PID datapath.
// Latency: all strobes decoded combinationally from the frame counter; wr_ack one cycle after wr.
// Flow control: none; frame-complete irq is built only when PID_SEQ_IRQ_EN is defined.
module pid_sequencer
    import pid_seq_pkg::*;
#(
    parameter int psc = 12,
    parameter int aw  = 1,
    parameter int cw  = CW_DEF,
    localparam int an = 1 << aw
) (
    input  logic                 clk_pid,
    input  logic                 reset,
    input  logic [an-1:0]        enable,
    input  logic                 wr,
    input  logic [aw-1:0]        wr_ch,
    input  logic [1:0]           wr_sel,
    input  logic signed [cw-1:0] wr_data,
    output logic                 wr_ack,
    input  logic [an-1:0]        clr_req,
    output logic [aw-1:0]        a,
    output logic [2:0]           step,
    output logic                 calc,
    output logic                 clr,
    output logic                 ce,
    output logic signed [cw-1:0] KP,
    output logic signed [cw-1:0] KI,
    output logic signed [cw-1:0] KD,
    output logic                 irq,
    input  logic                 irq_ack
);

    localparam int CNTW = psc + 3;
    localparam int OW   = psc - aw;
    localparam logic [OW-1:0] CALC_OFS = {1'b1, {(OW-1){1'b0}}};

    logic [CNTW-1:0] r_cnt;
    logic [an-1:0]   r_pend;
    logic            r_wr_ack;
    logic [OW-1:0]   w_ofs;
    logic            w_commit;
    logic [an-1:0]   w_pend_clr;

    assign step  = r_cnt[CNTW-1:psc];
    assign a     = r_cnt[psc-1:OW];
    assign w_ofs = r_cnt[OW-1:0];

    // ce marks slot start; calc sits mid-slot so m_k has settled half a slot.
    assign ce       = (w_ofs == '0);
    assign calc     = (w_ofs == CALC_OFS) && enable[a];
    assign w_commit = calc && (step == STEP_LATCH);
    assign clr      = w_commit && r_pend[a];

    assign w_pend_clr = clr ? (an'(1) << a) : '0;
    assign wr_ack     = r_wr_ack;

    always_ff @(posedge clk_pid) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_pend   <= '0;
            r_wr_ack <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_pend   <= (r_pend & ~w_pend_clr) | clr_req;
            r_wr_ack <= wr;
        end
    end

    pid_coef_bank #(
        .aw (aw),
        .cw (cw)
    ) u_coef_bank (
        .clk_pid   (clk_pid),
        .reset     (reset),
        .i_wr      (wr),
        .i_wr_ch   (wr_ch),
        .i_wr_sel  (wr_sel),
        .i_wr_data (wr_data),
        .i_commit  (w_commit),
        .i_a       (a),
        .o_kp      (KP),
        .o_ki      (KI),
        .o_kd      (KD)
    );

`ifdef PID_SEQ_IRQ_EN
    logic r_irq;

    // A wrap on the same edge as an ack wins, so no frame completion is lost.
    always_ff @(posedge clk_pid) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else if (&r_cnt) begin
            r_irq <= 1'b1;
        end else if (irq_ack) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0 & irq_ack;
`endif

endmodule

// File: tb/tb_pid_sequencer.sv
// Randomized scoreboard bench for pid_sequencer (psc=4, aw=1: 8-clock slots, 128-clock frames).
module tb_pid_sequencer;

    localparam int PSC   = 4;
    localparam int AW    = 1;
    localparam int CW    = 6;
    localparam int FRAME = 128;
    localparam int SLOT  = 8;

    logic        clk_pid = 1'b0;
    logic        reset   = 1'b0;
    logic [1:0]  enable  = 2'b00;
    logic        wr      = 1'b0;
    logic        wr_ch   = 1'b0;
    logic [1:0]  wr_sel  = 2'b00;
    logic [5:0]  wr_data = 6'd0;
    logic [1:0]  clr_req = 2'b00;
    logic        irq_ack = 1'b0;

    logic        wr_ack, calc, clr, ce, irq;
    logic        a;
    logic [2:0]  step;
    logic [5:0]  KP, KI, KD;

    always #5 clk_pid = ~clk_pid;

    pid_sequencer #(
        .psc (PSC),
        .aw  (AW),
        .cw  (CW)
    ) dut (
        .clk_pid (clk_pid),
        .reset   (reset),
        .enable  (enable),
        .wr      (wr),
        .wr_ch   (wr_ch),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .clr_req (clr_req),
        .a       (a),
        .step    (step),
        .calc    (calc),
        .clr     (clr),
        .ce      (ce),
        .KP      (KP),
        .KI      (KI),
        .KD      (KD),
        .irq     (irq),
        .irq_ack (irq_ack)
    );

    typedef struct packed {
        logic       a;
        logic [2:0] step;
        logic       calc;
        logic       clr;
        logic       ce;
        logic       ack;
        logic       irq;
        logic [5:0] kp;
        logic [5:0] ki;
        logic [5:0] kd;
    } snap_t;

    snap_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    tick        = 0;

    // Reference model: time since reset as an integer, coefficients as plain arrays.
    int         m_cyc;
    logic [5:0] m_stg [2][3];
    logic [5:0] m_act [2][3];
    logic       m_pend [2];
    logic       m_ack;
    logic       m_irq;

    task automatic apply(input logic rst, input logic [1:0] en, input logic w,
                         input logic ch, input logic [1:0] sel, input logic [5:0] dat,
                         input logic [1:0] creq, input logic iack, input bit chk);
        int    ca, cs, co;
        bit    c_calc, c_commit, c_clr;
        snap_t e;
        @(posedge clk_pid);
        #1;
        reset   = rst;
        enable  = en;
        wr      = w;
        wr_ch   = ch;
        wr_sel  = sel;
        wr_data = dat;
        clr_req = creq;
        irq_ack = iack;

        ca = (m_cyc / SLOT) % 2;
        cs = m_cyc / (2 * SLOT);
        co = m_cyc % SLOT;
        c_calc   = (co == SLOT / 2) && en[ca];
        c_commit = c_calc && (cs == 0);
        c_clr    = c_commit && m_pend[ca];
        if (chk) begin
            e.a    = ca[0];
            e.step = cs[2:0];
            e.calc = c_calc;
            e.clr  = c_clr;
            e.ce   = (co == 0);
            e.ack  = m_ack;
            e.irq  = m_irq;
            e.kp   = m_act[ca][0];
            e.ki   = m_act[ca][1];
            e.kd   = m_act[ca][2];
            exp_q.push_back(e);
        end

        if (!rst) begin
            m_cyc = 0;
            for (int c = 0; c < 2; c++) begin
                m_pend[c] = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    m_stg[c][s] = '0;
                    m_act[c][s] = '0;
                end
            end
            m_ack = 1'b0;
            m_irq = 1'b0;
        end else begin
            if (c_commit)
                for (int s = 0; s < 3; s++) m_act[ca][s] = m_stg[ca][s];
            if (w && sel != 2'd3) m_stg[ch][sel] = dat;
            m_ack = w;
            if (c_clr) m_pend[ca] = 1'b0;
            for (int c = 0; c < 2; c++) if (creq[c]) m_pend[c] = 1'b1;
`ifdef PID_SEQ_IRQ_EN
            if (m_cyc == FRAME - 1) m_irq = 1'b1;
            else if (iack) m_irq = 1'b0;
`endif
            m_cyc = (m_cyc + 1) % FRAME;
        end
    endtask

    always @(negedge clk_pid) begin : monitor
        snap_t e, g;
        tick++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {a, step, calc, clr, ce, wr_ack, irq, KP, KI, KD};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL outputs@tick%0d got a=%0b step=%0d calc=%0b clr=%0b ce=%0b ack=%0b irq=%0b K=%h/%h/%h exp a=%0b step=%0d calc=%0b clr=%0b ce=%0b ack=%0b irq=%0b K=%h/%h/%h",
                         tick, g.a, g.step, g.calc, g.clr, g.ce, g.ack, g.irq, g.kp, g.ki, g.kd,
                         e.a, e.step, e.calc, e.clr, e.ce, e.ack, e.irq, e.kp, e.ki, e.kd);
            end
        end
    end

    initial begin
        logic [1:0] en_r;
        logic       w, ch, iack, rst;
        logic [1:0] sel, creq;
        logic [5:0] dat;

        apply(1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 6'd0, 2'b00, 1'b0, 1'b0);

        // Directed frame: commit-edge write, mid-frame write, pending clears, irq, mask.
        for (int k = 0; k < 320; k++) begin
            w = 1'b0; ch = 1'b0; sel = 2'd0; dat = 6'd0; creq = 2'b00; iack = 1'b0;
            en_r = (k >= 150) ? 2'b01 : 2'b11;
            rst  = (k == 300) ? 1'b0 : 1'b1;
            if (k == 10)  begin w = 1'b1; ch = 1'b1; sel = 2'd0; dat = 6'd5;  end
            if (k == 4)   begin w = 1'b1; ch = 1'b0; sel = 2'd1; dat = 6'h3D; end
            if (k == 11)  begin w = 1'b1; ch = 1'b1; sel = 2'd3; dat = 6'h1F; end
            if (k == 12)  begin w = 1'b1; ch = 1'b1; sel = 2'd2; dat = 6'h21; end
            if (k == 2 || k == 12 || k == 160) creq = 2'b10;
            if (k == 200) begin w = 1'b1; ch = 1'b1; sel = 2'd1; dat = 6'd9; end
            if (k == 135) iack = 1'b1;
            if (k == 255) iack = 1'b1;
            apply(rst, en_r, w, ch, sel, dat, creq, iack, 1'b1);
        end

        en_r = 2'b11;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 63) == 0) en_r = 2'($urandom);
            w    = ($urandom_range(0, 3) == 0);
            ch   = 1'($urandom);
            sel  = 2'($urandom);
            dat  = 6'($urandom);
            creq = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            iack = ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 499) != 0);
            apply(rst, en_r, w, ch, sel, dat, creq, iack, 1'b1);
        end

        repeat (3) @(negedge clk_pid);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending expectations, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
